// File: rtl/ee357_4x32_demux_q.sv
// rtl/ee357_4x32_demux_q.sv - queued 1-to-4 demultiplexer with per-port valid/ready delivery
//
// Purpose:
//   Accepts a WIDTH-bit word and a 2-bit destination code per input handshake.
//   Buffers the pair in a DEPTH-entry FIFO and presents the head word to exactly
//   one of four destination ports. Delivery is strictly in order, so a stalled
//   head blocks every later word, including words bound for other ports.
//
// Optional feature macro: EE357_DEMUX_STATS_EN
//   When defined, four CW-bit wrapping counters count the words delivered to each port.
//   When undefined, stat_count is tied to zero and stat_sel is ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer has a word
//   in_ready   out  FIFO can accept (not full and out of reset)
//   in_data    in   word to deliver
//   in_sel     in   destination port 0..3
//   out_valid  out  one-hot destination of the head word (0 when empty)
//   out_ready  in   per-port consumer ready; only the head port's bit matters
//   out_data   out  head word on a shared bus (0 when empty)
//   occupancy  out  number of entries held
//   stat_sel   in   statistics counter select
//   stat_count out  delivered-word count for port stat_sel
module ee357_4x32_demux_q #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_sel,
  output logic [3:0]                 out_valid,
  input  logic [3:0]                 out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  input  logic [1:0]                 stat_sel,
  output logic [CW-1:0]              stat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [1:0]       r_mem_sel  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_head_sel;
  logic [3:0]       w_head_onehot;

  assign w_empty       = (r_occ == '0);
  assign w_full        = (r_occ == OW'(DEPTH));
  assign w_head_sel    = r_mem_sel[r_rd_ptr];
  assign w_head_onehot = 4'b0001 << w_head_sel;

  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign in_ready  = !w_full && rst_n;
  assign out_valid = w_empty ? 4'b0000 : w_head_onehot;
  assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign occupancy = r_occ;

  assign w_push = in_valid && in_ready;
  // Ready bits of non-head ports are masked off by the one-hot out_valid.
  assign w_pop  = |(out_valid & out_ready);

  // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_sel[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= in_data;
        r_mem_sel[r_wr_ptr]  <= in_sel;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef EE357_DEMUX_STATS_EN
  logic [CW-1:0] r_stat_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_stat_cnt[k] <= '0;
      end
    end else if (w_pop) begin
      r_stat_cnt[w_head_sel] <= r_stat_cnt[w_head_sel] + CW'(1);
    end
  end

  assign stat_count = r_stat_cnt[stat_sel];
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^stat_sel;
  assign stat_count        = '0;
`endif

endmodule
